// File: rtl/dfe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfe_pkg
// Description : Shared definitions for the DFE sample path: default sample
//               width and a saturating cast from a wide signed value.
// Revision    : 1.0 - initial release
// ============================================================================
package dfe_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Clamp a wide signed value into the signed range of 'width' bits.
    // The caller truncates the returned value to its own width.
    function automatic logic signed [63:0] sat_cast(input logic signed [63:0] value,
                                                    input int               width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfe_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dfe_sync_fifo
// Description : Single-clock show-ahead FIFO. Pointers carry an extra wrap
//               bit to tell full from empty. Read data is 0 when empty.
//               A write while full is taken only if a read happens on the
//               same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dfe_sync_fifo
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  do_rd;
    logic                  do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/decimator.sv
`default_nettype none
// ============================================================================
// Module      : decimator
// Description : Integer-factor down-sampler. Every DECIMATION_FACTOR accepted
//               samples produce one result (rounded mean or first sample),
//               queued in an output FIFO drained by valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module decimator
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter int DECIMATION_FACTOR = 2,
    parameter int FIFO_DEPTH        = 16,
    parameter int AVERAGE           = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_enable,
    input  logic signed [DATA_WIDTH-1:0] dec_in,
    input  logic                         dec_in_valid,
    output logic signed [DATA_WIDTH-1:0] dec_out,
    output logic                         dec_out_valid,
    input  logic                         dec_out_ready,
    output logic                         overflow
);

    localparam int             CW         = $clog2(DECIMATION_FACTOR);
    localparam logic [CW-1:0]  LAST_PHASE = CW'(DECIMATION_FACTOR - 1);

    logic [CW-1:0]                phase;
    logic                         accept;
    logic                         pop;
    logic                         group_done;
    logic signed [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0]        fifo_out;
    logic                         fifo_full;
    logic                         fifo_empty;

    assign accept        = clk_enable && dec_in_valid;
    assign pop           = clk_enable && dec_out_valid && dec_out_ready;
    assign group_done    = accept && (phase == LAST_PHASE);
    assign dec_out_valid = !fifo_empty;
    assign dec_out       = fifo_out;

    // Phase counts accepted samples, so input gaps do not split a group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (accept) begin
            phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
        end
    end

    generate
        if (AVERAGE != 0) begin : g_average
            localparam int                       ACC_W = DATA_WIDTH + CW;
            localparam int                       SUM_W = DATA_WIDTH + CW + 1;
            localparam logic signed [SUM_W-1:0]  ROUND = SUM_W'(2 ** (CW - 1));

            logic signed [ACC_W-1:0] acc;
            logic signed [SUM_W-1:0] sum;

            // Group sum including the closing sample plus half an LSB of the mean.
            assign sum = SUM_W'(acc) + SUM_W'(dec_in) + ROUND;

            // Accumulator restarts on the first sample of each group.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (accept) begin
                    if (phase == '0) acc <= ACC_W'(dec_in);
                    else             acc <= acc + ACC_W'(dec_in);
                end
            end

            assign result = DATA_WIDTH'(sat_cast(64'(sum >>> CW), DATA_WIDTH));
        end else begin : g_pick
            logic signed [DATA_WIDTH-1:0] first_sample;

            // Hold the first sample of the group until the group closes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    first_sample <= '0;
                end else if (accept && (phase == '0)) begin
                    first_sample <= dec_in;
                end
            end

            assign result = first_sample;
        end
    endgenerate

    // Sticky drop flag: a finished group found the queue full with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (group_done && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    dfe_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (group_done),
        .wr_data (result),
        .rd_en   (pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_decimator
// Description : Self-checking bench for decimator. Instance 'dut_a' is the
//               rounded-mean variant (M=2, depth 4); 'dut_b' is the pick
//               variant (M=4, depth 16). Expected results are queued as
//               stimulus is driven and popped when the DUT hands them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decimator;

    logic               clk;
    logic               rst_n;
    logic               clk_enable;

    logic signed [15:0] a_in, a_out;
    logic               a_in_valid, a_out_valid, a_out_ready, a_overflow;
    logic signed [15:0] b_in, b_out;
    logic               b_in_valid, b_out_valid, b_out_ready, b_overflow;

    logic signed [15:0] qa[$];
    logic signed [15:0] qb[$];
    longint             b_times[$];

    int vectors    = 0;
    int miscompares = 0;

    decimator #(
        .DATA_WIDTH(16), .DECIMATION_FACTOR(2), .FIFO_DEPTH(4), .AVERAGE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .dec_in(a_in), .dec_in_valid(a_in_valid),
        .dec_out(a_out), .dec_out_valid(a_out_valid), .dec_out_ready(a_out_ready),
        .overflow(a_overflow)
    );

    decimator #(
        .DATA_WIDTH(16), .DECIMATION_FACTOR(4), .FIFO_DEPTH(16), .AVERAGE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .dec_in(b_in), .dec_in_valid(b_in_valid),
        .dec_out(b_out), .dec_out_valid(b_out_valid), .dec_out_ready(b_out_ready),
        .overflow(b_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Reference rounded mean of two samples, clamped to 16-bit signed.
    function automatic logic signed [15:0] exp_avg(input int x, input int y);
        int s;
        s = (x + y + 1) >>> 1;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Scoreboard for dut_a: a handshake seen on the falling edge pops on the next rise.
    always @(negedge clk) begin
        if (rst_n && clk_enable && a_out_valid && a_out_ready) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_out_unexpected: got %0d, required no output", a_out);
            end else begin
                logic signed [15:0] e;
                e = qa.pop_front();
                if (a_out !== e) begin
                    miscompares++;
                    $display("FAIL a_out_value: got %0d, required %0d", a_out, e);
                end
            end
        end
    end

    // Scoreboard for dut_b, also logging when each result is handed out.
    always @(negedge clk) begin
        if (rst_n && clk_enable && b_out_valid && b_out_ready) begin
            vectors++;
            b_times.push_back($time);
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_out_unexpected: got %0d, required no output", b_out);
            end else begin
                logic signed [15:0] e;
                e = qb.pop_front();
                if (b_out !== e) begin
                    miscompares++;
                    $display("FAIL b_out_value: got %0d, required %0d", b_out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_empty();
        for (int n = 0; n < 40 && qa.size() != 0; n++) step();
    endtask

    task automatic wait_b_empty();
        for (int n = 0; n < 40 && qb.size() != 0; n++) step();
    endtask

    // Two back-to-back accepts on dut_a; optionally queue the expected mean.
    task automatic pair_a(input int x, input int y, input bit expect_out);
        a_in       = 16'(x);
        a_in_valid = 1'b1;
        step();
        a_in = 16'(y);
        if (expect_out) qa.push_back(exp_avg(x, y));
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        vectors += 6;
        if (a_out !== 16'sd0)     begin miscompares++; $display("FAIL reset_a_out: got %0d, required 0", a_out); end
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid: got %b, required 0", a_out_valid); end
        if (a_overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_a_overflow: got %b, required 0", a_overflow); end
        if (b_out !== 16'sd0)     begin miscompares++; $display("FAIL reset_b_out: got %0d, required 0", b_out); end
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid: got %b, required 0", b_out_valid); end
        if (b_overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_b_overflow: got %b, required 0", b_overflow); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clk_enable = 1'b1;
        step();
    endtask

    task automatic test_average();
        a_out_ready = 1'b1;
        pair_a(100, 200, 1'b1);
        vectors++;
        if (a_out_valid !== 1'b1 || a_out !== 16'sd150) begin
            miscompares++;
            $display("FAIL avg_latency_150: got valid=%b out=%0d, required valid=1 out=150", a_out_valid, a_out);
        end
        pair_a(300, -301, 1'b1);
        vectors++;
        if (a_out_valid !== 1'b1 || a_out !== 16'sd0) begin
            miscompares++;
            $display("FAIL avg_round_0: got valid=%b out=%0d, required valid=1 out=0", a_out_valid, a_out);
        end
        wait_a_empty();
        vectors++;
        if (qa.size() != 0) begin miscompares++; $display("FAIL avg_drain: got %0d outstanding, required 0", qa.size()); end
    endtask

    task automatic test_saturation();
        a_out_ready = 1'b1;
        pair_a(32767, 32767, 1'b1);
        pair_a(-32768, -32768, 1'b1);
        pair_a(32767, -32768, 1'b1);
        wait_a_empty();
        vectors++;
        if (qa.size() != 0) begin miscompares++; $display("FAIL sat_drain: got %0d outstanding, required 0", qa.size()); end
    endtask

    task automatic test_pick();
        b_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_in       = 16'(i);
            b_in_valid = 1'b1;
            if (i % 4 == 3) qb.push_back(16'(i - 3));
            step();
        end
        b_in_valid = 1'b0;
        wait_b_empty();
        vectors++;
        if (qb.size() != 0) begin miscompares++; $display("FAIL pick_drain: got %0d outstanding, required 0", qb.size()); end
        b_times.delete();
        for (int i = 0; i < 16; i++) begin
            b_in       = 16'(i);
            b_in_valid = 1'b1;
            if (i % 4 == 3) qb.push_back(16'(i - 3));
            step();
            b_in_valid = 1'b0;
            step();
        end
        wait_b_empty();
        vectors++;
        if (qb.size() != 0 || b_times.size() != 4) begin
            miscompares++;
            $display("FAIL pick_gapped_count: got %0d outstanding %0d outputs, required 0 and 4", qb.size(), b_times.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (b_times[i+1] - b_times[i] !== 64'sd80) begin
                    miscompares++;
                    $display("FAIL pick_gapped_spacing: got %0d, required 80", b_times[i+1] - b_times[i]);
                end
            end
        end
    endtask

    task automatic test_push_pop_full();
        a_out_ready = 1'b0;
        pair_a(1, 3, 1'b1);
        pair_a(5, 7, 1'b1);
        pair_a(9, 11, 1'b1);
        pair_a(13, 15, 1'b1);
        a_in       = 16'sd20;
        a_in_valid = 1'b1;
        step();
        a_in        = 16'sd30;
        a_out_ready = 1'b1;
        qa.push_back(exp_avg(20, 30));
        step();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        vectors++;
        if (a_overflow !== 1'b0 || a_out_valid !== 1'b1 || a_out !== 16'sd6) begin
            miscompares++;
            $display("FAIL full_push_pop: got ovf=%b valid=%b head=%0d, required ovf=0 valid=1 head=6",
                     a_overflow, a_out_valid, a_out);
        end
        a_out_ready = 1'b1;
        wait_a_empty();
        step();
        vectors++;
        if (qa.size() != 0 || a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: got %0d outstanding valid=%b, required 0 and valid=0", qa.size(), a_out_valid);
        end
    endtask

    task automatic test_clk_enable();
        a_out_ready = 1'b0;
        pair_a(2, 4, 1'b1);
        a_in       = 16'sd40;
        a_in_valid = 1'b1;
        step();
        clk_enable  = 1'b0;
        a_out_ready = 1'b1;
        a_in        = 16'sd999;
        repeat (3) step();
        vectors++;
        if (a_out_valid !== 1'b1 || a_out !== 16'sd3) begin
            miscompares++;
            $display("FAIL enable_freeze: got valid=%b head=%0d, required valid=1 head=3", a_out_valid, a_out);
        end
        clk_enable = 1'b1;
        a_in       = 16'sd60;
        qa.push_back(exp_avg(40, 60));
        step();
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out !== 16'sd50) begin
            miscompares++;
            $display("FAIL enable_resume: got valid=%b out=%0d, required valid=1 out=50", a_out_valid, a_out);
        end
        wait_a_empty();
        vectors++;
        if (qa.size() != 0) begin miscompares++; $display("FAIL enable_drain: got %0d outstanding, required 0", qa.size()); end
    endtask

    task automatic test_overflow();
        a_out_ready = 1'b0;
        for (int i = 1; i <= 7; i += 2) pair_a(i, i + 1, 1'b1);
        vectors++;
        if (a_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b, required 0", a_overflow); end
        pair_a(9, 10, 1'b0);
        vectors++;
        if (a_overflow !== 1'b1 || a_out !== 16'sd2) begin
            miscompares++;
            $display("FAIL ovf_set: got ovf=%b head=%0d, required ovf=1 head=2", a_overflow, a_out);
        end
        a_out_ready = 1'b1;
        wait_a_empty();
        step();
        vectors++;
        if (qa.size() != 0 || a_out_valid !== 1'b0 || a_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain: got %0d outstanding valid=%b ovf=%b, required 0 valid=0 ovf=1",
                     qa.size(), a_out_valid, a_overflow);
        end
    endtask

    task automatic test_reset_mid_group();
        a_out_ready = 1'b0;
        pair_a(7, 9, 1'b0);
        a_in       = 16'sd500;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (a_out !== 16'sd0 || a_out_valid !== 1'b0 || a_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got out=%0d valid=%b ovf=%b, required 0 0 0", a_out, a_out_valid, a_overflow);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_out_ready = 1'b1;
        pair_a(10, 20, 1'b1);
        vectors++;
        if (a_out_valid !== 1'b1 || a_out !== 16'sd15) begin
            miscompares++;
            $display("FAIL reset_next_pair: got valid=%b out=%0d, required valid=1 out=15", a_out_valid, a_out);
        end
        wait_a_empty();
        vectors++;
        if (qa.size() != 0) begin miscompares++; $display("FAIL reset_drain: got %0d outstanding, required 0", qa.size()); end
    endtask

    initial begin
        rst_n       = 1'b1;
        clk_enable  = 1'b0;
        a_in        = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in        = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        test_reset();
        test_average();
        test_saturation();
        test_pick();
        test_push_pop_full();
        test_clk_enable();
        test_overflow();
        test_reset_mid_group();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
